i2c_cfg_sequencer: RTL and testbench
====================================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Table-driven I2C configuration sequencer; successor to the fixed 6-device x 32-register redriver init controller.
//  Walks a register table of {last, dev_addr, offset, data} entries and issues one single-byte write per entry
//  to the byte-level I2C transaction engine. Adds optional read-back verify, bounded NACK retry and an error report.
//  Adds an inter-transaction gap and optional periodic refresh. Sits between the board-init FSM and the i2c_master engine.
// PARAMETERS
//  TBL_AW        5     table address width; depth = 2**TBL_AW entries
//  VERIFY_EN     1     1: read back every written entry and compare; 0: write-only
//  MAX_RETRY     3     re-issues of a NACKed/mismatched entry before error (0 = none)
//  GAP_CYC       250   idle iClk cycles between consecutive transactions (>=1)
//  REFRESH_CYC   0     0: run once per iStart; >0: auto-restart table this many cycles after DONE
//  CNT_W         24    width of gap/refresh counter; must hold max(GAP_CYC,REFRESH_CYC)
// PORTS
//  iClk        in   1        clock
//  iRstn       in   1        asynchronous active-low reset
//  iStart      in   1        1-cycle pulse; starts a pass from entry 0 (ignored while oBusy)
//  iAbort      in   1        level; stop after the outstanding response, go to IDLE, no error
//  oTblAddr    out  TBL_AW   table read address
//  iTblData    in   24       {last[23], dev[22:16], offset[15:8], data[7:0]}, valid 1 cycle after oTblAddr
//  oCmdValid   out  1        command request to engine
//  iCmdReady   in   1        engine accepts when oCmdValid&&iCmdReady
//  oCmdRead    out  1        1=read, 0=write
//  oCmdDev     out  7        7-bit device address
//  oCmdOffset  out  8        register offset
//  oCmdWData   out  8        write data
//  iRspValid   in   1        1-cycle completion pulse from engine
//  iRspNack    in   1        qualified by iRspValid: any NACK in transaction
//  iRspRData   in   8        qualified by iRspValid: read byte
//  oBusy       out  1        pass in progress
//  oDone       out  1        1-cycle pulse: pass completed with no error
//  oError      out  1        sticky; cleared on next accepted iStart
//  oErrIdx     out  TBL_AW   table index of failed entry (valid while oError)
//  oErrCode    out  2        01 NACK, 10 verify mismatch, 00 none
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; index 0; retry cnt 0; counters 0.
//  States: IDLE -> FETCH (drive oTblAddr=idx) -> LATCH (capture iTblData, 1-cycle ROM latency) -> WR_REQ -> WR_WAIT
//   -> [VERIFY_EN] RD_REQ -> RD_WAIT -> GAP -> FETCH(idx+1) | DONE -> IDLE | REFRESH_WAIT -> FETCH(idx=0).
//  Handshake: command fields stable while oCmdValid=1; oCmdValid deasserts the cycle after acceptance;
//   at most one outstanding command; iRspValid outside *_WAIT is ignored.
//  NACK or mismatch (iRspRData != data): retry cnt<MAX_RETRY -> cnt++, GAP, reissue same entry from WR_REQ;
//   else oError=1, oErrIdx=idx, oErrCode set, oBusy=0, -> IDLE (no oDone, no refresh).
//  Retry cnt clears on every entry advance. GAP counts GAP_CYC cycles, then FETCH.
//  End of table: entry with last=1, or idx==2**TBL_AW-1 (no wrap); oDone pulses the cycle DONE is entered.
//  Refresh: REFRESH_CYC>0 -> after DONE wait REFRESH_CYC cycles, restart at idx 0; oBusy=0 while waiting;
//   iStart during wait restarts immediately and clears the wait counter.
//  iAbort: honoured in FETCH/LATCH/GAP/REFRESH_WAIT immediately; in *_REQ/*_WAIT after response (or before
//   acceptance: drop oCmdValid); oError unchanged, no oDone. iAbort has priority over simultaneous iStart.
//  Simultaneous iRspValid & iAbort: response processed for error capture, then IDLE.
//  iStart while oBusy: ignored. Mid-pass async reset: immediate return to reset values.
// STRUCTURE
//  Package i2c_cfg_pkg: state encoding, entry field offsets (LAST_B=23, DEV_MSB/LSB, OFF_MSB/LSB, DAT_MSB/LSB),
//   ERR_NONE/ERR_NACK/ERR_VERIFY codes.
//  Sub-module i2c_cfg_timer: loadable down-counter (CNT_W) with zero flag, shared by GAP and REFRESH_WAIT.
//  Top: FSM, index/retry counters, entry latch, command/status registers.
// TESTING
//  3-entry table (dev 58 off 0E dat 04; 59/0F/2D; 5A/10/AE last), VERIFY_EN=0, engine ACKs -> 3 writes in order,
//   >=GAP_CYC idle between, oDone once, oError=0.
//  VERIFY_EN=1, engine returns AE for 5A/10 read -> 6 transactions (W,R per entry), oDone, no retry.
//  NACK on entry 1 twice then ACK, MAX_RETRY=3 -> entry 1 written 3 times, pass completes, oDone.
//  Readback of entry 1 = 2C vs 2D, always -> 4 attempts, oError=1, oErrIdx=1, oErrCode=10, no oDone.
//  iCmdReady held 0 for 50 cycles then iAbort -> oCmdValid drops, IDLE, oBusy=0, no oDone/oError.
//  REFRESH_CYC=1000, no last flag in 32-entry table -> stops at idx 31, oDone, restart at idx 0 after 1000 cycles.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg
//   Shared definitions for the table-driven I2C configuration sequencer:
//   FSM state encoding, bit positions of the fields inside a 24-bit table
//   entry, and the error codes reported on oErrCode.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_GAP,
    ST_DONE,
    ST_REFRESH_WAIT
  } state_e;

  // Table entry layout: {last, dev[6:0], offset[7:0], data[7:0]}
  localparam int ENTRY_W = 24;
  localparam int LAST_B  = 23;
  localparam int DEV_MSB = 22;
  localparam int DEV_LSB = 16;
  localparam int OFF_MSB = 15;
  localparam int OFF_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_NACK   = 2'b01,
    ERR_VERIFY = 2'b10
  } err_e;

endpackage

// File: rtl/i2c_cfg_timer.sv
// i2c_cfg_timer
//   Loadable down-counter with a zero flag. The sequencer shares one instance
//   between the inter-transaction gap and the refresh wait, since the two are
//   never active at the same time.
// Ports
//   iClk, iRstn : clock, asynchronous active-low reset
//   iLoad       : load iLoadVal this cycle (takes priority over counting)
//   iLoadVal    : value to load
//   oZero       : counter currently at zero
module i2c_cfg_timer
  import i2c_cfg_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  output logic             oZero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = iLoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oZero = (cnt_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
//   Walks a register table of {last, dev, offset, data} entries and issues one
//   single-byte I2C write per entry to the byte-level engine, optionally reading
//   each register back to verify it. NACKs and verify mismatches are retried up
//   to MAX_RETRY times before the pass stops with a sticky error. Consecutive
//   entries are separated by GAP_CYC idle cycles; with REFRESH_CYC > 0 the whole
//   table is replayed REFRESH_CYC cycles after each clean pass.
// Ports
//   iClk, iRstn                : clock, asynchronous active-low reset
//   iStart, iAbort             : start pulse / abort level from board-init FSM
//   oTblAddr, iTblData         : table ROM port (1-cycle read latency)
//   oCmd*, iCmdReady           : command request to the i2c_master engine
//   iRspValid/Nack/RData       : completion from the engine
//   oBusy, oDone               : pass in progress / clean completion pulse
//   oError, oErrIdx, oErrCode  : sticky failure report
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int TBL_AW      = 5,
  parameter int VERIFY_EN   = 1,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYC     = 250,
  parameter int REFRESH_CYC = 0,
  parameter int CNT_W       = 24
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iStart,
  input  logic              iAbort,
  output logic [TBL_AW-1:0] oTblAddr,
  input  logic [23:0]       iTblData,
  output logic              oCmdValid,
  input  logic              iCmdReady,
  output logic              oCmdRead,
  output logic [6:0]        oCmdDev,
  output logic [7:0]        oCmdOffset,
  output logic [7:0]        oCmdWData,
  input  logic              iRspValid,
  input  logic              iRspNack,
  input  logic [7:0]        iRspRData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError,
  output logic [TBL_AW-1:0] oErrIdx,
  output logic [1:0]        oErrCode
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  // Timer counts down to zero inclusive, so load one less than the wait length.
  localparam logic [CNT_W-1:0]   GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]   REF_LD    = (REFRESH_CYC > 0) ? CNT_W'(REFRESH_CYC - 1) : '0;
  localparam logic [TBL_AW-1:0]  IDX_LAST  = '1;

  state_e               state_q, state_d;
  logic [TBL_AW-1:0]    idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic                 err_q, err_d;
  logic [TBL_AW-1:0]    err_idx_q, err_idx_d;
  err_e                 err_code_q, err_code_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 gap_retry_q, gap_retry_d;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;

  logic                 rsp_fail;
  err_e                 rsp_code;
  logic                 at_end;
  logic                 abort_now;

  i2c_cfg_timer #(.CNT_W(CNT_W)) u_timer (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .iLoad    (tmr_load),
    .iLoadVal (tmr_val),
    .oZero    (tmr_zero)
  );

  // Mismatch only means something for a read response; a NACK wins over it.
  assign rsp_fail  = iRspNack ||
                     ((state_q == ST_RD_WAIT) && (iRspRData != entry_q[DAT_MSB:DAT_LSB]));
  assign rsp_code  = iRspNack ? ERR_NACK : ERR_VERIFY;
  assign at_end    = entry_q[LAST_B] || (idx_q == IDX_LAST);
  // An abort seen while a command is outstanding is remembered until the response.
  assign abort_now = iAbort || abort_pend_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    entry_d      = entry_q;
    err_d        = err_q;
    err_idx_d    = err_idx_q;
    err_code_d   = err_code_q;
    abort_pend_d = abort_pend_q;
    gap_retry_d  = gap_retry_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (iStart && !iAbort) begin
          state_d    = ST_FETCH;
          idx_d      = '0;
          retry_d    = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          err_code_d = ERR_NONE;
        end
      end

      ST_FETCH: begin
        state_d = iAbort ? ST_IDLE : ST_LATCH;
      end

      ST_LATCH: begin
        if (iAbort) begin
          state_d = ST_IDLE;
        end else begin
          entry_d = iTblData;
          state_d = ST_WR_REQ;
        end
      end

      ST_WR_REQ, ST_RD_REQ: begin
        // Once accepted the command must run to its response even if aborted.
        if (iCmdReady) begin
          state_d      = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
          abort_pend_d = abort_pend_q || iAbort;
        end else if (iAbort) begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_WAIT, ST_RD_WAIT: begin
        abort_pend_d = abort_pend_q || iAbort;
        if (iRspValid) begin
          if (rsp_fail) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
              if (abort_now) begin
                state_d = ST_IDLE;
              end else begin
                gap_retry_d = 1'b1;
                tmr_load    = 1'b1;
                tmr_val     = GAP_LD;
                state_d     = ST_GAP;
              end
            end else begin
              err_d      = 1'b1;
              err_idx_d  = idx_q;
              err_code_d = rsp_code;
              state_d    = ST_IDLE;
            end
          end else if (abort_now) begin
            state_d = ST_IDLE;
          end else if ((state_q == ST_WR_WAIT) && (VERIFY_EN != 0)) begin
            state_d = ST_RD_REQ;
          end else if (at_end) begin
            state_d = ST_DONE;
          end else begin
            idx_d       = idx_q + 1'b1;
            retry_d     = '0;
            gap_retry_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = GAP_LD;
            state_d     = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (iAbort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          // A retry reuses the latched entry; an advance must fetch the next one.
          state_d = gap_retry_q ? ST_WR_REQ : ST_FETCH;
        end
      end

      ST_DONE: begin
        if ((REFRESH_CYC > 0) && !iAbort) begin
          tmr_load = 1'b1;
          tmr_val  = REF_LD;
          state_d  = ST_REFRESH_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REFRESH_WAIT: begin
        if (iAbort) begin
          state_d = ST_IDLE;
        end else if (iStart || tmr_zero) begin
          if (iStart) begin
            tmr_load = 1'b1;
            tmr_val  = '0;
          end
          state_d    = ST_FETCH;
          idx_d      = '0;
          retry_d    = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          err_code_d = ERR_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      entry_q      <= '0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
      err_code_q   <= ERR_NONE;
      abort_pend_q <= 1'b0;
      gap_retry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      entry_q      <= entry_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
      err_code_q   <= err_code_d;
      abort_pend_q <= abort_pend_d;
      gap_retry_q  <= gap_retry_d;
    end
  end

  // Command fields come straight from the latched entry, so they stay stable
  // for as long as oCmdValid is held.
  assign oTblAddr   = idx_q;
  assign oCmdValid  = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign oCmdRead   = (state_q == ST_RD_REQ);
  assign oCmdDev    = entry_q[DEV_MSB:DEV_LSB];
  assign oCmdOffset = entry_q[OFF_MSB:OFF_LSB];
  assign oCmdWData  = entry_q[DAT_MSB:DAT_LSB];
  assign oBusy      = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                      (state_q != ST_REFRESH_WAIT);
  assign oDone      = (state_q == ST_DONE);
  assign oError     = err_q;
  assign oErrIdx    = err_idx_q;
  assign oErrCode   = err_code_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
module tb_i2c_cfg_sequencer;

  localparam int GAP  = 6;
  localparam int RCYC = 300;

  logic        iClk;
  logic        iRstn;
  logic        iStart;
  logic        iAbort;
  logic [4:0]  oTblAddr;
  logic [23:0] iTblData;
  logic        oCmdValid;
  logic        iCmdReady;
  logic        oCmdRead;
  logic [6:0]  oCmdDev;
  logic [7:0]  oCmdOffset;
  logic [7:0]  oCmdWData;
  logic        iRspValid;
  logic        iRspNack;
  logic [7:0]  iRspRData;
  logic        oBusy;
  logic        oDone;
  logic        oError;
  logic [4:0]  oErrIdx;
  logic [1:0]  oErrCode;

  i2c_cfg_sequencer #(
    .TBL_AW(5), .VERIFY_EN(1), .MAX_RETRY(3), .GAP_CYC(GAP),
    .REFRESH_CYC(RCYC), .CNT_W(16)
  ) dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iAbort(iAbort),
    .oTblAddr(oTblAddr), .iTblData(iTblData),
    .oCmdValid(oCmdValid), .iCmdReady(iCmdReady), .oCmdRead(oCmdRead),
    .oCmdDev(oCmdDev), .oCmdOffset(oCmdOffset), .oCmdWData(oCmdWData),
    .iRspValid(iRspValid), .iRspNack(iRspNack), .iRspRData(iRspRData),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oErrIdx(oErrIdx),
    .oErrCode(oErrCode)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------- table ROM model (1-cycle latency) ----------------
  logic [23:0] tbl [0:31];
  always @(posedge iClk) iTblData <= tbl[oTblAddr];

  // ---------------- engine model ----------------
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [23:0] log_cmd [0:255];
  int          log_gap [0:255];
  int          rsp_cnt = 0;
  int          last_rsp_cyc = 0;
  logic        pend_rd = 1'b0;
  logic [6:0]  pend_dev = 7'h00;
  logic [7:0]  last_wd = 8'h00;
  int          nack_given = 0;
  int          nack_limit = 0;
  logic [6:0]  nack_dev = 7'h7F;
  logic [6:0]  corrupt_dev = 7'h7F;

  always @(negedge iClk) begin
    cyc = cyc + 1;
    iRspValid = 1'b0;
    iRspNack  = 1'b0;
    iRspRData = 8'h00;
    if (!iRstn) begin
      rsp_cnt = 0;
    end else if (rsp_cnt != 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        iRspValid = 1'b1;
        if (!pend_rd && pend_dev == nack_dev && nack_given < nack_limit) begin
          iRspNack   = 1'b1;
          nack_given = nack_given + 1;
        end
        if (pend_rd) iRspRData = (pend_dev == corrupt_dev) ? (last_wd ^ 8'h01) : last_wd;
        last_rsp_cyc = cyc;
      end
    end else if (oCmdValid && iCmdReady) begin
      log_cmd[acc_cnt & 255] = {oCmdRead, oCmdDev, oCmdOffset, oCmdWData};
      log_gap[acc_cnt & 255] = cyc - last_rsp_cyc;
      acc_cnt  = acc_cnt + 1;
      pend_rd  = oCmdRead;
      pend_dev = oCmdDev;
      if (!oCmdRead) last_wd = oCmdWData;
      rsp_cnt  = 3;
    end
  end

  // ---------------- scoreboard / checking ----------------
  typedef struct packed {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] off;
    logic [7:0] wd;
    logic       gap;
  } exp_t;

  exp_t exp_q[$];
  int   rd_ptr = 0;
  int   done_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rd, input logic [6:0] dev, input logic [7:0] off,
                      input logic [7:0] wd, input logic gap);
    exp_q.push_back({rd, dev, off, wd, gap});
  endtask

  task automatic push_wr(input logic [6:0] dev, input logic [7:0] off,
                         input logic [7:0] wd, input logic gap);
    push(1'b0, dev, off, wd, gap);
    push(1'b1, dev, off, wd, 1'b0);
  endtask

  task automatic drain();
    logic [23:0] c;
    int          g;
    exp_t        e;
    while (rd_ptr < acc_cnt) begin
      c = log_cmd[rd_ptr & 255];
      g = log_gap[rd_ptr & 255];
      rd_ptr++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%06h expected=none", c);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cmd_rd",  {31'd0, c[23]},    {31'd0, e.rd});
        chk("cmd_dev", {25'd0, c[22:16]}, {25'd0, e.dev});
        chk("cmd_off", {24'd0, c[15:8]},  {24'd0, e.off});
        if (!e.rd) chk("cmd_wdata", {24'd0, c[7:0]}, {24'd0, e.wd});
        if (e.gap) chk("gap_min", {31'd0, (g >= GAP)}, 32'd1);
      end
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    if (oDone) done_cnt++;
    drain();
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic pulse_abort();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
  endtask

  function automatic logic [23:0] mk(input logic last, input logic [6:0] dev,
                                     input logic [7:0] off, input logic [7:0] dat);
    return {last, dev, off, dat};
  endfunction

  task automatic load_small();
    for (int i = 0; i < 32; i++) tbl[i] = 24'h0;
    tbl[0] = mk(1'b0, 7'h58, 8'h0E, 8'h04);
    tbl[1] = mk(1'b0, 7'h59, 8'h0F, 8'h2D);
    tbl[2] = mk(1'b1, 7'h5A, 8'h10, 8'hAE);
  endtask

  int d0;
  int t_done;
  int t_busy;

  initial begin
    iRstn = 1'b0; iStart = 1'b0; iAbort = 1'b0; iCmdReady = 1'b1;
    load_small();
    tick(); tick(); tick();
    chk("rst_busy",  {31'd0, oBusy},     32'd0);
    chk("rst_valid", {31'd0, oCmdValid}, 32'd0);
    chk("rst_err",   {31'd0, oError},    32'd0);
    chk("rst_addr",  {27'd0, oTblAddr},  32'd0);
    chk("rst_dev",   {25'd0, oCmdDev},   32'd0);
    iRstn = 1'b1;
    tick(); tick();
    chk("idle_done", {31'd0, oDone}, 32'd0);

    // 3-entry pass, all ACK, readback matches
    push_wr(7'h58, 8'h0E, 8'h04, 1'b0);
    push_wr(7'h59, 8'h0F, 8'h2D, 1'b1);
    push_wr(7'h5A, 8'h10, 8'hAE, 1'b1);
    d0 = done_cnt;
    pulse_start();
    chk("t1_busy", {31'd0, oBusy}, 32'd1);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_err",       {31'd0, oError}, 32'd0);
    chk("t1_busy_end",  {31'd0, oBusy},  32'd0);
    chk("t1_sb_empty",  exp_q.size(),    32'd0);
    pulse_abort();
    tick();

    // entry 1 NACKed twice then ACKed
    nack_dev   = 7'h59;
    nack_limit = nack_given + 2;
    push_wr(7'h58, 8'h0E, 8'h04, 1'b0);
    push(1'b0, 7'h59, 8'h0F, 8'h2D, 1'b1);
    push(1'b0, 7'h59, 8'h0F, 8'h2D, 1'b1);
    push_wr(7'h59, 8'h0F, 8'h2D, 1'b1);
    push_wr(7'h5A, 8'h10, 8'hAE, 1'b1);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk("t2_done_once", done_cnt - d0, 32'd1);
    chk("t2_err",       {31'd0, oError}, 32'd0);
    chk("t2_sb_empty",  exp_q.size(),    32'd0);
    chk("t2_nacks",     nack_given,      32'd2);
    pulse_abort();
    tick();
    nack_dev = 7'h7F;

    // entry 1 readback always 2C -> 4 attempts then verify error
    corrupt_dev = 7'h59;
    push_wr(7'h58, 8'h0E, 8'h04, 1'b0);
    for (int i = 0; i < 4; i++) push_wr(7'h59, 8'h0F, 8'h2D, 1'b1);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (oError) break;
      tick();
    end
    chk("t3_err",      {31'd0, oError},   32'd1);
    chk("t3_err_idx",  {27'd0, oErrIdx},  32'd1);
    chk("t3_err_code", {30'd0, oErrCode}, 32'd2);
    chk("t3_busy",     {31'd0, oBusy},    32'd0);
    for (int i = 0; i < RCYC + 50; i++) tick();
    chk("t3_no_done",  done_cnt - d0,     32'd0);
    chk("t3_no_refr",  {31'd0, oBusy},    32'd0);
    chk("t3_sb_empty", exp_q.size(),      32'd0);
    corrupt_dev = 7'h7F;

    // engine stalls, then abort before acceptance
    iCmdReady = 1'b0;
    d0 = done_cnt;
    pulse_start();
    chk("t4_err_clr", {31'd0, oError}, 32'd0);
    for (int i = 0; i < 50; i++) tick();
    chk("t4_valid", {31'd0, oCmdValid}, 32'd1);
    chk("t4_dev",   {25'd0, oCmdDev},   32'h58);
    chk("t4_off",   {24'd0, oCmdOffset}, 32'h0E);
    pulse_abort();
    chk("t4_valid_drop", {31'd0, oCmdValid}, 32'd0);
    chk("t4_busy",       {31'd0, oBusy},     32'd0);
    iCmdReady = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t4_no_done", done_cnt - d0,   32'd0);
    chk("t4_no_err",  {31'd0, oError}, 32'd0);

    // 32 entries, no last flag, refresh after DONE
    for (int i = 0; i < 32; i++) begin
      tbl[i] = mk(1'b0, 7'(7'h20 + i), 8'(i), 8'(i * 3 + 1));
      push_wr(7'(7'h20 + i), 8'(i), 8'(i * 3 + 1), (i != 0));
    end
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    t_done = cyc;
    chk("t5_done_once", done_cnt - d0,   32'd1);
    chk("t5_last_idx",  {27'd0, oTblAddr}, 32'd31);
    chk("t5_sb_empty",  exp_q.size(),    32'd0);
    tick();
    chk("t5_wait_busy", {31'd0, oBusy}, 32'd0);
    for (int i = 0; i < RCYC + 20; i++) begin
      if (oBusy) break;
      tick();
    end
    t_busy = cyc;
    chk("t5_refresh_delay",
        {31'd0, ((t_busy - t_done) >= RCYC) && ((t_busy - t_done) <= RCYC + 2)}, 32'd1);
    chk("t5_restart_idx", {27'd0, oTblAddr}, 32'd0);
    pulse_abort();
    chk("t5_abort_busy", {31'd0, oBusy}, 32'd0);

    // asynchronous reset in the middle of a pass
    load_small();
    iCmdReady = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    chk("t6_pre_valid", {31'd0, oCmdValid}, 32'd1);
    #2 iRstn = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, oCmdValid}, 32'd0);
    chk("t6_rst_busy",  {31'd0, oBusy},     32'd0);
    chk("t6_rst_dev",   {25'd0, oCmdDev},   32'd0);
    tick();
    iRstn = 1'b1;
    iCmdReady = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
